// File: rtl/dmem_pkg.sv
// Shared types and helpers for the STRV32I data-memory responder.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 30;

  typedef logic [31:0]           word_t;
  typedef logic [WORD_BYTES-1:0] mask_t;
  typedef logic [IDX_W-1:0]      idx_t;

  typedef struct packed {
    idx_t  idx;
    word_t data;
    mask_t mask;
  } wbuf_t;

  // Bytes whose mask bit is set come from new_word, the rest from old_word.
  function automatic word_t byte_merge(word_t old_word, word_t new_word, mask_t mask);
    word_t merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data port bundle; the core is the master, the memory the slave.
interface dmem_responder_if #(
  parameter int CNT_W = 16
);
  import dmem_pkg::*;

  logic [31:0]      dm_addr;
  word_t            dm_data_out;
  mask_t            dm_wr_mask;
  logic             dm_wr_req;
  word_t            dm_data_in;
  logic             dm_err;
  logic [CNT_W-1:0] store_count;

  modport master (
    output dm_addr, dm_data_out, dm_wr_mask, dm_wr_req,
    input  dm_data_in, dm_err, store_count
  );

  modport slave (
    input  dm_addr, dm_data_out, dm_wr_mask, dm_wr_req,
    output dm_data_in, dm_err, store_count
  );

endinterface

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables, synchronous write and
// combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  word_t         wr_data,
  input  mask_t         wr_mask,
  input  logic [AW-1:0] rd_idx,
  output word_t         rd_data
);

  word_t mem [DEPTH_WORDS];

  // NOTE: the storage has no reset; clearing it would need a sequencer and
  // would stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: address decode, one-entry write buffer with
// store-to-load forwarding, registered load data, error flag and store counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  idx_t             idx;
  logic             in_range;
  logic             mask_nz;
  logic             store_acc;
  logic             fwd_hit;
  word_t            rd_data;
  word_t            load_word;

  wbuf_t            wbuf;
  logic             wbuf_valid;
  word_t            data_q;
  logic             err_q;
  logic [CNT_W-1:0] count_q;

  // The subtraction wraps for addresses below BASE_ADDR; the >= term rejects those.
  assign idx       = idx_t'((bus.dm_addr - BASE_ADDR) >> 2);
  assign in_range  = (bus.dm_addr >= BASE_ADDR) && (idx < idx_t'(DEPTH_WORDS));
  assign mask_nz   = |bus.dm_wr_mask;
  assign store_acc = bus.dm_wr_req && in_range && mask_nz;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .wr_en   (wbuf_valid),
    .wr_idx  (wbuf.idx[AW-1:0]),
    .wr_data (wbuf.data),
    .wr_mask (wbuf.mask),
    .rd_idx  (idx[AW-1:0]),
    .rd_data (rd_data)
  );

  // The buffered store commits at this same edge, so a load of that word
  // must take the buffered bytes or it would return stale data.
  assign fwd_hit   = wbuf_valid && (wbuf.idx == idx);
  assign load_word = fwd_hit ? byte_merge(rd_data, wbuf.data, wbuf.mask) : rd_data;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; commit-old and load-new rely on that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf       <= '0;
      wbuf_valid <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      wbuf_valid <= store_acc;
      if (store_acc) begin
        wbuf    <= '{idx: idx, data: bus.dm_data_out, mask: bus.dm_wr_mask};
        count_q <= count_q + CNT_W'(1);
      end

      if (bus.dm_wr_req) begin
        data_q <= '0;
        err_q  <= !in_range && mask_nz;
      end else begin
        data_q <= in_range ? load_word : '0;
        err_q  <= !in_range;
      end
    end
  end

  assign bus.dm_data_in  = data_q;
  assign bus.dm_err      = err_q;
  assign bus.store_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          CW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.CNT_W(CW)) bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: the latest architectural value of each word, updated the
  // moment a store is accepted (forwarding makes that visible to loads).
  logic [31:0] model_mem [DEPTH];
  int unsigned model_count = 0;
  int errors = 0;
  int checks = 0;

  task automatic drive(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask);
    bus.dm_wr_req   = wr;
    bus.dm_addr     = addr;
    bus.dm_data_out = data;
    bus.dm_wr_mask  = mask;
  endtask

  // One request cycle: drive, clock, then compare all three outputs.
  task automatic op(input string name, input bit wr, input logic [31:0] addr,
                    input logic [31:0] data, input logic [3:0] mask);
    logic [31:0] off;
    int unsigned widx;
    bit          inr;
    logic [31:0] exp_data;
    bit          exp_err;
    off  = addr - BASE;
    widx = off >> 2;
    inr  = (addr >= BASE) && (widx < DEPTH);
    if (wr) begin
      exp_data = 32'h0;
      exp_err  = !inr && (mask != 4'h0);
      if (inr && mask != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) model_mem[widx][8*b +: 8] = data[8*b +: 8];
        model_count = (model_count + 1) % (1 << CW);
      end
    end else begin
      exp_data = inr ? model_mem[widx] : 32'h0;
      exp_err  = !inr;
    end
    @(negedge clk);
    drive(wr, addr, data, mask);
    @(posedge clk);
    #1;
    checks++;
    if (bus.dm_data_in !== exp_data) begin
      errors++;
      $display("FAIL %s data @%h: got %h want %h", name, addr, bus.dm_data_in, exp_data);
    end
    checks++;
    if (bus.dm_err !== exp_err) begin
      errors++;
      $display("FAIL %s err @%h: got %b want %b", name, addr, bus.dm_err, exp_err);
    end
    checks++;
    if (bus.store_count !== CW'(model_count)) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", name, bus.store_count, model_count);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h8, 32'h1234_5678, 4'hF);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i[0] == 1'b0, 32'h8 + 32'(4 * i), 32'hCAFE_0000 + 32'(i), 4'hF);
      @(posedge clk);
      #1;
      checks++;
      if (bus.dm_data_in !== 32'h0 || bus.dm_err !== 1'b0 || bus.store_count !== '0) begin
        errors++;
        $display("FAIL reset_hold: got data=%h err=%b cnt=%0d want 0/0/0",
                 bus.dm_data_in, bus.dm_err, bus.store_count);
      end
    end
    @(negedge clk);
    drive(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.store_count !== '0 || bus.dm_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cnt=%0d err=%b want 0/0", bus.store_count, bus.dm_err);
    end
    model_count = 0;
  endtask

  task automatic test_fill();
    for (int w = 0; w < DEPTH; w++) op("fill", 1'b1, BASE + 32'(4 * w), $urandom, 4'hF);
    for (int w = 0; w < DEPTH; w += 17) op("fill_rd", 1'b0, BASE + 32'(4 * w), 32'h0, 4'h0);
  endtask

  task automatic test_forward();
    int unsigned c0;
    c0 = model_count;
    op("fwd_st", 1'b1, 32'h08, 32'h0128_2423, 4'hF);
    op("fwd_ld", 1'b0, 32'h08, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'h0128_2423) begin
      errors++;
      $display("FAIL fwd_value: got %h want 01282423", bus.dm_data_in);
    end
    op("fwd_gap", 1'b0, 32'h00, 32'h0, 4'h0);
    op("arr_ld", 1'b0, 32'h08, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'h0128_2423 || bus.store_count !== CW'(c0 + 1)) begin
      errors++;
      $display("FAIL arr_value: got %h cnt=%0d want 01282423 cnt=%0d",
               bus.dm_data_in, bus.store_count, c0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    op("b2b_st0", 1'b1, 32'h10, 32'hAABB_CCDD, 4'hF);
    op("b2b_st1", 1'b1, 32'h10, 32'h1122_3344, 4'b0011);
    op("b2b_ld", 1'b0, 32'h10, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'hAABB_3344) begin
      errors++;
      $display("FAIL b2b_value: got %h want aabb3344", bus.dm_data_in);
    end
    op("adj_st0", 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
    op("adj_st1", 1'b1, 32'h24, 32'h0BAD_F00D, 4'hF);
    op("adj_ld0", 1'b0, 32'h20, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL adj_value0: got %h want deadbeef", bus.dm_data_in);
    end
    op("adj_ld1", 1'b0, 32'h24, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL adj_value1: got %h want 0badf00d", bus.dm_data_in);
    end
    c0 = model_count;
    op("mask0_st", 1'b1, 32'h20, 32'h5555_5555, 4'h0);
    op("mask0_ld", 1'b0, 32'h20, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'hDEAD_BEEF || bus.store_count !== CW'(c0)) begin
      errors++;
      $display("FAIL mask0_value: got %h cnt=%0d want deadbeef cnt=%0d",
               bus.dm_data_in, bus.store_count, c0);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] oor;
    oor = BASE + 32'(4 * DEPTH);
    op("oor_st", 1'b1, oor, 32'h7777_7777, 4'hF);
    op("oor_ld", 1'b0, oor, 32'h0, 4'h0);
    op("oor_ld_hi", 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0);
    op("oor_next", 1'b0, 32'h24, 32'h0, 4'h0);
    op("oor_last_word", 1'b0, oor - 32'h1, 32'h0, 4'h0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4095));
      else if ($urandom_range(0, 1) == 0) addr = BASE + 32'($urandom_range(0, 31));
      else addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      op("rand", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_discard();
    op("rd_st0", 1'b1, 32'h30, 32'h0, 4'hF);
    op("rd_gap0", 1'b0, 32'h00, 32'h0, 4'h0);
    op("rd_gap1", 1'b0, 32'h04, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.dm_data_in !== 32'h0 || bus.dm_err !== 1'b0 || bus.store_count !== '0) begin
      errors++;
      $display("FAIL async_reset: got data=%h err=%b cnt=%0d want 0/0/0",
               bus.dm_data_in, bus.dm_err, bus.store_count);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    model_count = 0;
    op("rd_ld", 1'b0, 32'h30, 32'h0, 4'h0);
    checks++;
    if (bus.dm_data_in !== 32'h0) begin
      errors++;
      $display("FAIL discard_value: got %h want 00000000", bus.dm_data_in);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_forward();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_reset_discard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
